hdc_ngram_fusion_encoder: RTL and testbench

Parametrised multi-modality temporal encoder for the late-fusion HDC pipeline. It sits between the spatial encoder and the associative memory. It replaces the per-modality fixed-trigram temporal encoder instances with one block that has a single shared valid/ready handshake. Per modality it keeps a history of the last NGRAM spatial hypervectors and emits their rotate-and-XOR N-gram. It optionally emits a majority-fused hypervector across modalities for early-fusion experiments.

---
 rtl/hdc_ngram_fusion_encoder_if.sv | 35 +++
 rtl/hdc_ngram_fusion_encoder.sv | 142 ++++++++++++++
 tb/tb_hdc_ngram_fusion_encoder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hdc_ngram_fusion_encoder_if.sv
// Shared valid/ready bundle for the multi-modality N-gram encoder.
// FusedOut_DO only exists when HDC_FUSION_EN is defined.
interface hdc_ngram_fusion_encoder_if #(
  parameter int HV_DIM  = 2048,
  parameter int NUM_MOD = 3
);
  logic                        ValidIn_SI;
  logic                        ReadyOut_SO;
  logic [0:NUM_MOD*HV_DIM-1]   HypervectorIn_DI;
  logic                        Flush_SI;
  logic                        ValidOut_SO;
  logic                        ReadyIn_SI;
  logic [0:NUM_MOD*HV_DIM-1]   HypervectorOut_DO;
`ifdef HDC_FUSION_EN
  logic [0:HV_DIM-1]           FusedOut_DO;

  modport slave (
    input  ValidIn_SI, HypervectorIn_DI, Flush_SI, ReadyIn_SI,
    output ReadyOut_SO, ValidOut_SO, HypervectorOut_DO, FusedOut_DO
  );
  modport master (
    output ValidIn_SI, HypervectorIn_DI, Flush_SI, ReadyIn_SI,
    input  ReadyOut_SO, ValidOut_SO, HypervectorOut_DO, FusedOut_DO
  );
`else
  modport slave (
    input  ValidIn_SI, HypervectorIn_DI, Flush_SI, ReadyIn_SI,
    output ReadyOut_SO, ValidOut_SO, HypervectorOut_DO
  );
  modport master (
    output ValidIn_SI, HypervectorIn_DI, Flush_SI, ReadyIn_SI,
    input  ReadyOut_SO, ValidOut_SO, HypervectorOut_DO
  );
`endif
endinterface

// File: rtl/hdc_ngram_fusion_encoder.sv
// Per-modality rotate-and-XOR N-gram encoder with one shared handshake.
// Define HDC_FUSION_EN to add the registered cross-modality majority output.
module hdc_ngram_fusion_encoder #(
  parameter int HV_DIM  = 2048,
  parameter int NUM_MOD = 3,
  parameter int NGRAM   = 3
) (
  input  logic                      Clk_CI,
  input  logic                      Reset_RI,
  hdc_ngram_fusion_encoder_if.slave bus
);

  localparam int VEC_W  = NUM_MOD * HV_DIM;
  localparam int FILL_W = $clog2(NGRAM + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NGRAM);

  typedef enum logic {ST_FILL, ST_STREAM} state_t;

  state_t              state_reg, state_next;
  logic [FILL_W-1:0]   fill_cnt_reg, fill_cnt_next;
  logic [0:HV_DIM-1]   hist_reg [NUM_MOD][NGRAM];
  logic [0:HV_DIM-1]   window   [NUM_MOD][NGRAM];
  logic [0:NGRAM-1]    taps     [NUM_MOD][HV_DIM];
  logic [0:VEC_W-1]    ngram_vec;
  logic [0:VEC_W-1]    hv_out_reg;
  logic                valid_out_reg, valid_out_next;
  logic                ready;
  logic                accept;
  logic                load;

  // Ready looks only at flush, reset and the output slot, never at ValidIn_SI.
  assign ready  = ~Reset_RI & ~bus.Flush_SI & (~valid_out_reg | bus.ReadyIn_SI);
  assign accept = bus.ValidIn_SI & ready;

  generate
    for (genvar gm = 0; gm < NUM_MOD; gm++) begin : g_mod
      for (genvar gi = 0; gi < NGRAM; gi++) begin : g_win
        if (gi == 0) begin : g_head
          assign window[gm][gi] = bus.HypervectorIn_DI[gm*HV_DIM +: HV_DIM];
        end else begin : g_tail
          assign window[gm][gi] = hist_reg[gm][gi-1];
        end
        // rot_gi(x)[j] = x[(j - gi) mod HV_DIM], with bit 0 leftmost.
        for (genvar gj = 0; gj < HV_DIM; gj++) begin : g_rot
          assign taps[gm][gj][gi] = window[gm][gi][(gj - gi + HV_DIM) % HV_DIM];
        end
      end
      for (genvar gj = 0; gj < HV_DIM; gj++) begin : g_xor
        assign ngram_vec[gm*HV_DIM + gj] = ^taps[gm][gj];
      end
    end
  endgenerate

`ifdef HDC_FUSION_EN
  logic [0:NUM_MOD-1] column [HV_DIM];
  logic [0:HV_DIM-1]  fused_vec;
  logic [0:HV_DIM-1]  fused_reg;

  generate
    for (genvar gj = 0; gj < HV_DIM; gj++) begin : g_fuse
      for (genvar gm = 0; gm < NUM_MOD; gm++) begin : g_col
        assign column[gj][gm] = ngram_vec[gm*HV_DIM + gj];
      end
      // Ties can only happen with an even modality count; modality 0 breaks them.
      assign fused_vec[gj] = (2 * $countones(column[gj]) > NUM_MOD)  ? 1'b1 :
                             (2 * $countones(column[gj]) == NUM_MOD) ? column[gj][0] :
                                                                       1'b0;
    end
  endgenerate

  assign bus.FusedOut_DO = fused_reg;
`endif

  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    load          = 1'b0;
    if (bus.Flush_SI) begin
      state_next    = ST_FILL;
      fill_cnt_next = '0;
    end else if (accept) begin
      case (state_reg)
        ST_FILL: begin
          fill_cnt_next = fill_cnt_reg + 1'b1;
          if (fill_cnt_next == FILL_FULL) begin
            load       = 1'b1;
            state_next = ST_STREAM;
          end
        end
        ST_STREAM: load = 1'b1;
        default:   state_next = ST_FILL;
      endcase
    end
  end

  always_comb begin
    valid_out_next = valid_out_reg;
    if (bus.Flush_SI)
      valid_out_next = 1'b0;
    else if (load)
      valid_out_next = 1'b1;
    else if (bus.ReadyIn_SI)
      valid_out_next = 1'b0;
  end

  always_ff @(posedge Clk_CI or posedge Reset_RI) begin
    if (Reset_RI) begin
      state_reg     <= ST_FILL;
      fill_cnt_reg  <= '0;
      valid_out_reg <= 1'b0;
      hv_out_reg    <= '0;
      for (int m = 0; m < NUM_MOD; m++)
        for (int i = 0; i < NGRAM; i++)
          hist_reg[m][i] <= '0;
`ifdef HDC_FUSION_EN
      fused_reg     <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      fill_cnt_reg  <= fill_cnt_next;
      valid_out_reg <= valid_out_next;
      if (bus.Flush_SI) begin
        for (int m = 0; m < NUM_MOD; m++)
          for (int i = 0; i < NGRAM; i++)
            hist_reg[m][i] <= '0;
      end else if (accept) begin
        hist_reg <= window;
      end
      if (load) begin
        hv_out_reg <= ngram_vec;
`ifdef HDC_FUSION_EN
        fused_reg  <= fused_vec;
`endif
      end
    end
  end

  assign bus.ReadyOut_SO       = ready;
  assign bus.ValidOut_SO       = valid_out_reg;
  assign bus.HypervectorOut_DO = hv_out_reg;

endmodule

// File: tb/tb_hdc_ngram_fusion_encoder.sv
// Directed bench for hdc_ngram_fusion_encoder (HV_DIM=8, NUM_MOD=3, NGRAM=3);
// the fusion instances are only built when HDC_FUSION_EN is defined.
module tb_hdc_ngram_fusion_encoder;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hdc_ngram_fusion_encoder_if #(.HV_DIM(8), .NUM_MOD(3)) bus ();
  hdc_ngram_fusion_encoder #(.HV_DIM(8), .NUM_MOD(3), .NGRAM(3)) dut (
    .Clk_CI   (clk),
    .Reset_RI (rst),
    .bus      (bus)
  );

`ifdef HDC_FUSION_EN
  hdc_ngram_fusion_encoder_if #(.HV_DIM(8), .NUM_MOD(3)) fb3 ();
  hdc_ngram_fusion_encoder #(.HV_DIM(8), .NUM_MOD(3), .NGRAM(1)) dut_f3 (
    .Clk_CI   (clk),
    .Reset_RI (rst),
    .bus      (fb3)
  );
  hdc_ngram_fusion_encoder_if #(.HV_DIM(8), .NUM_MOD(2)) fb2 ();
  hdc_ngram_fusion_encoder #(.HV_DIM(8), .NUM_MOD(2), .NGRAM(1)) dut_f2 (
    .Clk_CI   (clk),
    .Reset_RI (rst),
    .bus      (fb2)
  );
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                  = 1'b1;
    bus.ValidIn_SI       = 1'b0;
    bus.Flush_SI         = 1'b0;
    bus.ReadyIn_SI       = 1'b1;
    bus.HypervectorIn_DI = '0;
`ifdef HDC_FUSION_EN
    fb3.ValidIn_SI = 1'b0; fb3.Flush_SI = 1'b0; fb3.ReadyIn_SI = 1'b1; fb3.HypervectorIn_DI = '0;
    fb2.ValidIn_SI = 1'b0; fb2.Flush_SI = 1'b0; fb2.ReadyIn_SI = 1'b1; fb2.HypervectorIn_DI = '0;
`endif
    repeat (3) tick();
    check("rst_ready",  64'(bus.ReadyOut_SO), 64'h0);
    check("rst_valid",  64'(bus.ValidOut_SO), 64'h0);
    check("rst_hv",     64'(bus.HypervectorOut_DO), 64'h0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(bus.ReadyOut_SO), 64'h1);

    // Fill: three 8'h80 vectors, output only after the third.
    bus.ValidIn_SI       = 1'b1;
    bus.HypervectorIn_DI = 24'h808080;
    tick();
    check("fill1_valid", 64'(bus.ValidOut_SO), 64'h0);
    tick();
    check("fill2_valid", 64'(bus.ValidOut_SO), 64'h0);
    tick();
    check("fill3_valid", 64'(bus.ValidOut_SO), 64'h1);
    check("fill3_hv",    64'(bus.HypervectorOut_DO), 64'hE0E0E0);

    // Wrap-around: 8'h01 shifts in, last bit rotates to bit 0.
    bus.HypervectorIn_DI = 24'h010101;
    tick();
    check("wrap1_hv", 64'(bus.HypervectorOut_DO), 64'h616161);
    tick();
    check("wrap2_hv", 64'(bus.HypervectorOut_DO), 64'hA1A1A1);
    tick();
    check("wrap3_hv",    64'(bus.HypervectorOut_DO), 64'hC1C1C1);
    check("wrap3_valid", 64'(bus.ValidOut_SO), 64'h1);

    // Backpressure for five cycles; offered vector must wait.
    bus.ReadyIn_SI       = 1'b0;
    bus.HypervectorIn_DI = 24'hAAAAAA;
    #1;
    check("bp_ready0", 64'(bus.ReadyOut_SO), 64'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp%0d_ready", c), 64'(bus.ReadyOut_SO), 64'h0);
      check($sformatf("bp%0d_valid", c), 64'(bus.ValidOut_SO), 64'h1);
      check($sformatf("bp%0d_hv", c),    64'(bus.HypervectorOut_DO), 64'hC1C1C1);
    end
    bus.ReadyIn_SI = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.ReadyOut_SO), 64'h1);
    tick();
    check("bp_release_hv", 64'(bus.HypervectorOut_DO), 64'h6A6A6A);

    // Flush after two accepts; the flush-cycle vector is dropped.
    bus.HypervectorIn_DI = 24'h111111;
    tick();
    bus.HypervectorIn_DI = 24'h222222;
    tick();
    bus.Flush_SI         = 1'b1;
    bus.HypervectorIn_DI = 24'hFFFFFF;
    #1;
    check("flush_ready", 64'(bus.ReadyOut_SO), 64'h0);
    tick();
    check("flush_valid", 64'(bus.ValidOut_SO), 64'h0);
    bus.Flush_SI         = 1'b0;
    bus.HypervectorIn_DI = 24'h808080;
    tick();
    check("refill1_valid", 64'(bus.ValidOut_SO), 64'h0);
    tick();
    check("refill2_valid", 64'(bus.ValidOut_SO), 64'h0);
    tick();
    check("refill3_valid", 64'(bus.ValidOut_SO), 64'h1);
    check("refill3_hv",    64'(bus.HypervectorOut_DO), 64'hE0E0E0);

    // Drain with no new input.
    bus.ValidIn_SI = 1'b0;
    tick();
    check("drain_valid", 64'(bus.ValidOut_SO), 64'h0);

    // Reset mid-stream, asserted between clock edges.
    bus.ValidIn_SI = 1'b1;
    tick();
    check("pre_rst_valid", 64'(bus.ValidOut_SO), 64'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(bus.ValidOut_SO), 64'h0);
    check("async_rst_hv",    64'(bus.HypervectorOut_DO), 64'h0);
    check("async_rst_ready", 64'(bus.ReadyOut_SO), 64'h0);
    tick();
    rst                  = 1'b0;
    bus.HypervectorIn_DI = 24'h010101;
    tick();
    check("rfill1_valid", 64'(bus.ValidOut_SO), 64'h0);
    tick();
    check("rfill2_valid", 64'(bus.ValidOut_SO), 64'h0);
    tick();
    check("rfill3_valid", 64'(bus.ValidOut_SO), 64'h1);
    check("rfill3_hv",    64'(bus.HypervectorOut_DO), 64'hC1C1C1);

`ifdef HDC_FUSION_EN
    fb3.ValidIn_SI       = 1'b1;
    fb3.HypervectorIn_DI = 24'hF0CCAA;
    fb2.ValidIn_SI       = 1'b1;
    fb2.HypervectorIn_DI = 16'hF00F;
    tick();
    check("fuse3_valid", 64'(fb3.ValidOut_SO), 64'h1);
    check("fuse3_hv",    64'(fb3.HypervectorOut_DO), 64'hF0CCAA);
    check("fuse3_maj",   64'(fb3.FusedOut_DO), 64'hE8);
    check("fuse2_tie",   64'(fb2.FusedOut_DO), 64'hF0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
